sub8bc2_stream: RTL



---
 rtl/sub8bc2_stream_pkg.sv | 23 ++
 rtl/sub_sat_core.sv | 32 +++
 rtl/sub8bc2_stream.sv | 104 ++++++++++
 3 files changed

// File: rtl/sub8bc2_stream_pkg.sv
// rtl/sub8bc2_stream_pkg.sv - shared saturation constants and element-count defaults
package sub8bc2_stream_pkg;

  localparam int DATA_W_DFLT  = 8;
  localparam int N_ELEMS_DFLT = 25;
  localparam int CNT_W_DFLT   = 5;

  // Largest positive two's-complement value of width w (0111..1), shared with the adder.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement value of width w (1000..0).
  function automatic logic [31:0] sat_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic last;
  } s2_flags_t;

endpackage

// File: rtl/sub_sat_core.sv
// rtl/sub_sat_core.sv - combinational saturating a-b with overflow flag
module sub_sat_core
  import sub8bc2_stream_pkg::*;
#(
  parameter int W = DATA_W_DFLT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W-1:0] raw;
  logic         pos_ovf;
  logic         neg_ovf;

  // Direct subtraction: negating b first would overflow for b = MIN_V.
  assign raw     = a_i - b_i;
  assign pos_ovf = !a_i[W-1] &&  b_i[W-1] &&  raw[W-1];
  assign neg_ovf =  a_i[W-1] && !b_i[W-1] && !raw[W-1];
  assign ovf_o   = pos_ovf || neg_ovf;

  always_comb begin
    diff_o = raw;
    if (pos_ovf) diff_o = MAX_V;
    else if (neg_ovf) diff_o = MIN_V;
  end

endmodule

// File: rtl/sub8bc2_stream.sv
// rtl/sub8bc2_stream.sv - two-stage streaming saturating subtractor with matrix tracking
module sub8bc2_stream
  import sub8bc2_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int N_ELEMS = N_ELEMS_DFLT,
  parameter int CNT_W   = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_diff,
  output logic              out_ovf,
  output logic              out_last,
  output logic              mat_ovf,
  output logic [CNT_W-1:0]  elem_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEMS - 1);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] diff_q;
  s2_flags_t         flags_q;
  logic [CNT_W-1:0]  idx_q;
  logic              mat_q, mat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_free, in_fire, s2_load;
  logic [DATA_W-1:0] core_diff;
  logic              core_ovf;

  sub_sat_core #(.W(DATA_W)) u_core (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .diff_o (core_diff),
    .ovf_o  (core_ovf)
  );

  // S2 can take a new element when empty or when its current one leaves this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_free;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    mat_d      = mat_q;
    if (in_fire) s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      cnt_d      = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      mat_d      = (cnt_q == '0) ? core_ovf : (mat_q || core_ovf);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      flags_q    <= '0;
      idx_q      <= '0;
      mat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      mat_q      <= mat_d;
      if (in_fire) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
      end
      if (s2_load) begin
        diff_q       <= core_diff;
        flags_q.ovf  <= core_ovf;
        flags_q.last <= (cnt_q == LAST_IDX);
        idx_q        <= cnt_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_diff  = diff_q;
  assign out_ovf   = flags_q.ovf;
  assign out_last  = flags_q.last;
  assign mat_ovf   = mat_q;
  assign elem_idx  = idx_q;

endmodule
